sd_spi_block_writer: RTL and testbench

SPI-mode SD card block writer. It is the write-direction counterpart of the SD picture reader. It accepts a stream of 16-bit pixel words and writes them to the card as one 512-byte block per request, using CMD24 (WRITE_SINGLE_BLOCK). It sits between a frame-capture source (SDRAM readback) and the SD SPI pins, after card initialisation has completed elsewhere.

---
 rtl/sd_spi_block_writer_if.sv | 9 +
 rtl/sd_spi_block_writer.sv | 198 +++++++++++++++++++
 tb/tb_sd_spi_block_writer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_spi_block_writer_if.sv
// rtl/sd_spi_block_writer_if.sv - pixel word stream into the SD block writer
interface sd_spi_block_writer_if;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/sd_spi_block_writer.sv
// rtl/sd_spi_block_writer.sv - CMD24 single-block writer over SPI-mode SD
// Streams 256 16-bit words (high byte first) into one 512-byte block per request.
module sd_spi_block_writer #(
  parameter int CLK_DIV  = 2,
  parameter int NCR_MAX  = 8,
  parameter int BUSY_MAX = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init_done,
  input  logic                       start,
  input  logic [31:0]                blk_addr,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [2:0]                 err_code,
  sd_spi_block_writer_if.slave       wr,
  output logic                       sd_clk,
  output logic                       sd_cs,
  output logic                       sd_mosi,
  input  logic                       sd_miso
);

  localparam int DW = $clog2(CLK_DIV);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_CMD, S_R1, S_GAP, S_TOKEN, S_DATA,
    S_CRC, S_DRESP, S_BUSYW, S_STOP, S_FIN
  } state_t;

  state_t        state;
  logic [31:0]   addr;
  logic [15:0]   cnt;
  logic [7:0]    word_lo;
  logic [6:0]    tx_shift;
  logic [7:0]    rx_shift;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic          eng_active;
  logic          evt;
  logic [7:0]    tx_byte;
  logic          hs;
  logic          launch;

  assign hs = wr.wr_ready && wr.wr_valid;

  // Byte to launch next; in DATA the high byte comes straight off the bus at the handshake.
  always_comb begin
    tx_byte = 8'hFF;
    case (state)
      S_CMD: begin
        case (cnt[2:0])
          3'd0:    tx_byte = 8'h58;
          3'd1:    tx_byte = addr[31:24];
          3'd2:    tx_byte = addr[23:16];
          3'd3:    tx_byte = addr[15:8];
          3'd4:    tx_byte = addr[7:0];
          default: tx_byte = 8'hFF;
        endcase
      end
      S_TOKEN: tx_byte = 8'hFE;
      S_DATA:  tx_byte = cnt[0] ? word_lo : wr.wr_data[15:8];
      default: tx_byte = 8'hFF;
    endcase
  end

  assign launch = !eng_active && !evt && (state != S_IDLE) && (state != S_FIN) &&
                  ((state != S_DATA) || cnt[0] || hs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      addr        <= '0;
      cnt         <= '0;
      word_lo     <= '0;
      tx_shift    <= '1;
      rx_shift    <= '1;
      bit_cnt     <= '0;
      div_cnt     <= '0;
      eng_active  <= 1'b0;
      evt         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= 3'd0;
      wr.wr_ready <= 1'b0;
      sd_clk      <= 1'b0;
      sd_cs       <= 1'b1;
      sd_mosi     <= 1'b1;
    end else begin
      done <= 1'b0;
      evt  <= 1'b0;
      if (eng_active) begin
        if (div_cnt == DW'(CLK_DIV - 1)) begin
          div_cnt <= '0;
          if (!sd_clk) begin
            sd_clk <= 1'b1;
          end else begin
            sd_clk   <= 1'b0;
            rx_shift <= {rx_shift[6:0], sd_miso};
            if (bit_cnt == 3'd7) begin
              eng_active <= 1'b0;
              evt        <= 1'b1;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              sd_mosi  <= tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b1};
            end
          end
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end else if (evt) begin
        // rx_shift now holds the complete byte that just finished.
        case (state)
          S_PRE: begin state <= S_CMD; cnt <= '0; end
          S_CMD: begin
            if (cnt == 16'd5) begin state <= S_R1; cnt <= '0; end
            else cnt <= cnt + 16'd1;
          end
          S_R1: begin
            if (rx_shift == 8'hFF) begin
              if (cnt == 16'(NCR_MAX - 1)) begin
                err <= 1'b1; err_code <= 3'd1; state <= S_STOP;
              end else cnt <= cnt + 16'd1;
            end else if (rx_shift == 8'h00) begin
              state <= S_GAP;
            end else begin
              err <= 1'b1; err_code <= 3'd2; state <= S_STOP;
            end
          end
          S_GAP:   state <= S_TOKEN;
          S_TOKEN: begin state <= S_DATA; cnt <= '0; end
          S_DATA: begin
            if (cnt == 16'd511) begin state <= S_CRC; cnt <= '0; end
            else cnt <= cnt + 16'd1;
          end
          S_CRC: begin
            if (cnt == 16'd1) begin state <= S_DRESP; cnt <= '0; end
            else cnt <= cnt + 16'd1;
          end
          S_DRESP: begin
            if (rx_shift == 8'hFF) begin
              if (cnt == 16'(NCR_MAX - 1)) begin
                err <= 1'b1; err_code <= 3'd3; state <= S_STOP;
              end else cnt <= cnt + 16'd1;
            end else if (rx_shift[4:0] == 5'h05) begin
              state <= S_BUSYW; cnt <= '0;
            end else begin
              err <= 1'b1; err_code <= 3'd3; state <= S_STOP;
            end
          end
          S_BUSYW: begin
            if (rx_shift == 8'hFF) begin
              state <= S_STOP;
            end else if (cnt == 16'(BUSY_MAX - 1)) begin
              err <= 1'b1; err_code <= 3'd4; state <= S_STOP;
            end else cnt <= cnt + 16'd1;
          end
          S_STOP:  state <= S_FIN;
          default: state <= S_IDLE;
        endcase
      end else if (launch) begin
        tx_shift   <= tx_byte[6:0];
        sd_mosi    <= tx_byte[7];
        bit_cnt    <= '0;
        div_cnt    <= '0;
        eng_active <= 1'b1;
        sd_cs      <= (state == S_PRE) || (state == S_STOP);
        if (state == S_DATA && !cnt[0]) begin
          word_lo     <= wr.wr_data[7:0];
          wr.wr_ready <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (start && init_done) begin
              addr     <= blk_addr;
              busy     <= 1'b1;
              err      <= 1'b0;
              err_code <= 3'd0;
              cnt      <= '0;
              state    <= S_PRE;
            end
          end
          S_FIN: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          S_DATA:  wr.wr_ready <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_block_writer.sv
// tb/tb_sd_spi_block_writer.sv - directed bench for the SD SPI block writer
// A small SPI card model answers CMD24 and logs every byte seen on MOSI.
module tb_sd_spi_block_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic        start;
  logic [31:0] blk_addr;
  logic        busy, done, err;
  logic [2:0]  err_code;
  logic        sd_clk, sd_cs, sd_mosi;
  logic        sd_miso;

  sd_spi_block_writer_if bus();

  sd_spi_block_writer dut (
    .clk(clk), .rst(rst), .init_done(init_done), .start(start), .blk_addr(blk_addr),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .wr(bus),
    .sd_clk(sd_clk), .sd_cs(sd_cs), .sd_mosi(sd_mosi), .sd_miso(sd_miso)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;

  // Word source
  int   idx;
  logic valid_en;
  logic data_mode;

  function automatic logic [15:0] word_of(input int i, input logic mode);
    logic [7:0] lo;
    lo = i[7:0];
    return mode ? {~lo, lo} : {8'h00, lo};
  endfunction

  assign bus.wr_data  = word_of(idx, data_mode);
  assign bus.wr_valid = valid_en;

  always @(posedge clk or posedge rst) begin
    if (rst) idx <= 0;
    else if (bus.wr_ready && bus.wr_valid) idx <= idx + 1;
  end

  // Card model
  typedef enum {C_CMD, C_R1, C_TOK, C_DATA, C_CRC, C_DRESP, C_BUSY} cphase_t;
  cphase_t    cph;
  int         bitn, cidx, busy_left, nbytes;
  logic [7:0] mosi_sh, miso_sh, next_resp;
  logic [7:0] log_b [0:1023];
  logic [7:0] cfg_r1, cfg_dresp;
  logic       cfg_r1_to;
  int         cfg_busy;

  task automatic card_reset();
    bitn = 0; cidx = 0; busy_left = 0; nbytes = 0;
    cph = C_CMD; mosi_sh = 8'h00; miso_sh = 8'hFF; next_resp = 8'hFF; sd_miso = 1'b1;
  endtask

  always @(posedge sd_clk) begin
    logic [7:0] b;
    b = {mosi_sh[6:0], sd_mosi};
    mosi_sh = b;
    bitn++;
    if (bitn == 8) begin
      bitn = 0;
      if (nbytes < 1024) log_b[nbytes] = b;
      nbytes++;
      next_resp = 8'hFF;
      if (sd_cs) begin
        cph = C_CMD; cidx = 0;
      end else begin
        case (cph)
          C_CMD: begin
            cidx++;
            if (cidx == 6) begin cph = C_R1; if (!cfg_r1_to) next_resp = cfg_r1; end
          end
          C_R1:  cph = C_TOK;
          C_TOK: if (b == 8'hFE) begin cph = C_DATA; cidx = 0; end
          C_DATA: begin cidx++; if (cidx == 512) begin cph = C_CRC; cidx = 0; end end
          C_CRC: begin cidx++; if (cidx == 2) begin cph = C_DRESP; next_resp = cfg_dresp; end end
          C_DRESP: begin
            cph = C_BUSY; busy_left = cfg_busy;
            if (busy_left > 0) begin next_resp = 8'h00; busy_left--; end
          end
          C_BUSY: if (busy_left > 0) begin next_resp = 8'h00; busy_left--; end
          default: ;
        endcase
      end
    end
  end

  always @(negedge sd_clk) begin
    if (bitn == 0) miso_sh = next_resp;
    else miso_sh = {miso_sh[6:0], 1'b1};
    sd_miso = miso_sh[7];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    card_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_req(input logic [31:0] a);
    @(negedge clk);
    blk_addr = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output logic e, output logic [2:0] ec);
    logic got;
    got = 1'b0; e = 1'bx; ec = 3'bx;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; e = err; ec = err_code; break; end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_hdr(input string tag, input logic [31:0] a);
    logic [7:0] exp_b [0:9];
    exp_b = '{8'hFF, 8'h58, a[31:24], a[23:16], a[15:8], a[7:0], 8'hFF, 8'hFF, 8'hFF, 8'hFE};
    for (int i = 0; i < 10; i++)
      check($sformatf("%s_hdr%0d", tag, i), 32'(log_b[i]), 32'(exp_b[i]));
  endtask

  task automatic check_data(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = word_of(i, data_mode);
      if (log_b[10 + 2*i] !== w[15:8] || log_b[11 + 2*i] !== w[7:0]) bad++;
    end
    check({tag, "_data_bytes_bad"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic       e;
    logic [2:0] ec;
    logic       got;
    logic       clk_hi;

    checks = 0; failures = 0;
    rst = 1'b1; init_done = 1'b0; start = 1'b0; blk_addr = '0;
    valid_en = 1'b1; data_mode = 1'b0;
    cfg_r1 = 8'h00; cfg_r1_to = 1'b0; cfg_dresp = 8'hE5; cfg_busy = 3;
    card_reset();
    repeat (3) @(negedge clk);

    check("rst_sd_cs", 32'(sd_cs), 32'd1);
    check("rst_sd_mosi", 32'(sd_mosi), 32'd1);
    check("rst_sd_clk", 32'(sd_clk), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // start with init_done low is ignored
    start_req(32'h0000_1234);
    repeat (40) @(negedge clk);
    check("noinit_busy", 32'(busy), 32'd0);
    check("noinit_bytes", 32'(nbytes), 32'd0);
    init_done = 1'b1;

    // Test 1: good write
    start_req(32'h0000_1234);
    check("t1_busy", 32'(busy), 32'd1);
    start_req(32'hFFFF_0000);
    wait_done("t1", e, ec);
    check("t1_err", 32'(e), 32'd0);
    check("t1_err_code", 32'(ec), 32'd0);
    check("t1_handshakes", 32'(idx), 32'd256);
    check("t1_bytes", 32'(nbytes), 32'd530);
    check_hdr("t1", 32'h0000_1234);
    check_data("t1");
    for (int i = 522; i < 530; i++)
      check($sformatf("t1_tail%0d", i), 32'(log_b[i]), 32'hFF);
    check("t1_cs_after", 32'(sd_cs), 32'd1);
    repeat (100) @(negedge clk);
    check("t1_no_restart", 32'(busy), 32'd0);
    check("t1_bytes_after", 32'(nbytes), 32'd530);

    // Test 2: R1 nonzero
    do_reset();
    cfg_r1 = 8'h04;
    start_req(32'h0000_0055);
    wait_done("t2", e, ec);
    check("t2_err", 32'(e), 32'd1);
    check("t2_err_code", 32'(ec), 32'd2);
    check("t2_handshakes", 32'(idx), 32'd0);
    check("t2_bytes", 32'(nbytes), 32'd9);
    check("t2_stop_byte", 32'(log_b[8]), 32'hFF);
    check("t2_cs_after", 32'(sd_cs), 32'd1);

    // Test 3: R1 timeout
    do_reset();
    cfg_r1_to = 1'b1;
    start_req(32'h0000_0077);
    wait_done("t3", e, ec);
    check("t3_err", 32'(e), 32'd1);
    check("t3_err_code", 32'(ec), 32'd1);
    check("t3_bytes", 32'(nbytes), 32'd16);
    check("t3_cs_after", 32'(sd_cs), 32'd1);
    cfg_r1_to = 1'b0; cfg_r1 = 8'h00;

    // Test 4: data rejected
    do_reset();
    cfg_dresp = 8'h0B;
    start_req(32'h00AB_CDEF);
    wait_done("t4", e, ec);
    check("t4_err", 32'(e), 32'd1);
    check("t4_err_code", 32'(ec), 32'd3);
    check("t4_handshakes", 32'(idx), 32'd256);
    check("t4_bytes", 32'(nbytes), 32'd526);
    cfg_dresp = 8'hE5;

    // Test 6: reset mid-DATA
    do_reset();
    start_req(32'h0000_1234);
    got = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (idx >= 20) begin got = 1'b1; break; end
    end
    check("t6_reached_data", 32'(got), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_sd_cs", 32'(sd_cs), 32'd1);
    check("t6_sd_clk", 32'(sd_clk), 32'd0);
    check("t6_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    card_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Test 5 (also the post-reset rerun): stall before word 100
    data_mode = 1'b1;
    start_req(32'hDEAD_BEEF);
    got = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (idx >= 100) begin got = 1'b1; break; end
    end
    check("t5_reached_100", 32'(got), 32'd1);
    valid_en = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.wr_ready) begin got = 1'b1; break; end
    end
    check("t5_ready_in_stall", 32'(got), 32'd1);
    clk_hi = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (sd_clk) clk_hi = 1'b1;
    end
    check("t5_sd_clk_low_stall", 32'(clk_hi), 32'd0);
    check("t5_idx_stalled", 32'(idx), 32'd100);
    valid_en = 1'b1;
    wait_done("t5", e, ec);
    check("t5_err", 32'(e), 32'd0);
    check("t5_handshakes", 32'(idx), 32'd256);
    check("t5_bytes", 32'(nbytes), 32'd530);
    check_hdr("t5", 32'hDEAD_BEEF);
    check_data("t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
